// File: rtl/gemm_core.sv
// GEMM execution core: decodes one GEMM instruction and runs acc += W*x for every
// micro-op of an iter_out x iter_in loop, using external 1-cycle-latency memories.
module gemm_core #(
    parameter int UOP_WIDTH = 32,
    parameter int UPC_WIDTH = 13,
    parameter int INS_WIDTH = 128,
    parameter int INP_WIDTH = 8,
    parameter int WGT_WIDTH = 8,
    parameter int ACC_WIDTH = 32,
    parameter int INP_DEPTH = 16,
    parameter int WGT_DEPTH = 256,
    parameter int ACC_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [INS_WIDTH-1:0]           insn,
    input  logic [UOP_WIDTH-1:0]           uop,
    output logic [UPC_WIDTH-1:0]           upc,
    input  logic [ACC_WIDTH*ACC_DEPTH-1:0] acc_mem_rd_data,
    output logic [11:0]                    acc_mem_rd_addr,
    output logic [ACC_WIDTH*ACC_DEPTH-1:0] acc_mem_wr_data,
    output logic [11:0]                    acc_mem_wr_addr,
    output logic [ACC_WIDTH*ACC_DEPTH/8-1:0] acc_mem_wr_we,
    input  logic [INP_WIDTH*INP_DEPTH-1:0] inp_mem_rd_data,
    output logic [31:0]                    inp_mem_rd_addr,
    input  logic [WGT_WIDTH*WGT_DEPTH-1:0] wgt_mem_rd_data,
    output logic [31:0]                    wgt_mem_rd_addr,
    output logic [8*ACC_DEPTH-1:0]         out_mem_wr_data,
    output logic [31:0]                    out_mem_wr_addr,
    output logic [ACC_DEPTH-1:0]           out_mem_wr_we
);
    localparam int PW = INP_WIDTH + WGT_WIDTH;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, READ, EXEC, WB, DONE} state_t;
    state_t state_reg, state_next;

    logic        rr_reg;
    logic [12:0] bgn_reg;
    logic [13:0] end_reg, iout_reg, iin_reg;
    logic [10:0] dfo_reg, dfi_reg, sfo_reg, sfi_reg;
    logic [9:0]  wfo_reg, wfi_reg;
    logic [13:0] i_reg, j_reg, pc_reg;
    logic [11:0] acc_idx_reg;
    logic [31:0] inp_idx_reg, wgt_idx_reg;
    logic [ACC_WIDTH*ACC_DEPTH-1:0] res_reg;
    logic [ACC_WIDTH*ACC_DEPTH-1:0] new_vec;

    logic is_gemm, degenerate;
    logic [13:0] pc_inc, j_inc, i_inc;
    logic pc_wrap, j_wrap, last_iter;
    logic unused_insn;

    assign unused_insn = ^{insn[6:3], insn[INS_WIDTH-1]};
    assign is_gemm     = (insn[2:0] == 3'd2);
    assign degenerate  = (insn[48:35] == '0) || (insn[62:49] == '0)
                       || (insn[34:21] <= {1'b0, insn[20:8]});

    assign pc_inc    = pc_reg + 14'd1;
    assign j_inc     = j_reg + 14'd1;
    assign i_inc     = i_reg + 14'd1;
    assign pc_wrap   = (pc_inc == end_reg);
    assign j_wrap    = pc_wrap && (j_inc == iin_reg);
    assign last_iter = j_wrap && (i_inc == iout_reg);

    // One dot-product row per output element, signed 8x8 products summed at full accumulator width
    for (genvar gi = 0; gi < ACC_DEPTH; gi++) begin : g_row
        logic [ACC_WIDTH-1:0] dot;
        logic signed [PW-1:0] prod;
        always_comb begin
            prod = '0;
            dot  = acc_mem_rd_data[gi*ACC_WIDTH +: ACC_WIDTH];
            for (int n = 0; n < INP_DEPTH; n++) begin
                prod = $signed(inp_mem_rd_data[n*INP_WIDTH +: INP_WIDTH])
                     * $signed(wgt_mem_rd_data[(gi*INP_DEPTH+n)*WGT_WIDTH +: WGT_WIDTH]);
                dot  = dot + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
            end
        end
        assign new_vec[gi*ACC_WIDTH +: ACC_WIDTH] = dot;
        assign out_mem_wr_data[gi*8 +: 8]         = res_reg[gi*ACC_WIDTH +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (is_gemm) state_next = degenerate ? DONE : FETCH;
            FETCH:   state_next = DECODE;
            DECODE:  state_next = READ;
            READ:    state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = last_iter ? DONE : FETCH;
            DONE:    if (!is_gemm) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_reg <= 1'b0;   bgn_reg <= '0;  end_reg <= '0;
            iout_reg <= '0;   iin_reg <= '0;
            dfo_reg <= '0;    dfi_reg <= '0;  sfo_reg <= '0;  sfi_reg <= '0;
            wfo_reg <= '0;    wfi_reg <= '0;
            i_reg <= '0;      j_reg <= '0;    pc_reg <= '0;
            acc_idx_reg <= '0; inp_idx_reg <= '0; wgt_idx_reg <= '0;
            res_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: if (is_gemm) begin
                    rr_reg   <= insn[7];
                    bgn_reg  <= insn[20:8];
                    end_reg  <= insn[34:21];
                    iout_reg <= insn[48:35];
                    iin_reg  <= insn[62:49];
                    dfo_reg  <= insn[73:63];
                    dfi_reg  <= insn[84:74];
                    sfo_reg  <= insn[95:85];
                    sfi_reg  <= insn[106:96];
                    wfo_reg  <= insn[116:107];
                    wfi_reg  <= insn[126:117];
                    i_reg    <= '0;
                    j_reg    <= '0;
                    pc_reg   <= {1'b0, insn[20:8]};
                end
                DECODE: begin
                    acc_idx_reg <= 12'(uop[10:0]) + 12'(i_reg) * 12'(dfo_reg) + 12'(j_reg) * 12'(dfi_reg);
                    inp_idx_reg <= 32'(uop[21:11]) + 32'(i_reg) * 32'(sfo_reg) + 32'(j_reg) * 32'(sfi_reg);
                    wgt_idx_reg <= 32'(uop[31:22]) + 32'(i_reg) * 32'(wfo_reg) + 32'(j_reg) * 32'(wfi_reg);
                end
                EXEC: res_reg <= rr_reg ? '0 : new_vec;
                WB: begin
                    pc_reg <= pc_wrap ? {1'b0, bgn_reg} : pc_inc;
                    if (pc_wrap) j_reg <= j_wrap ? '0 : j_inc;
                    if (j_wrap)  i_reg <= i_inc;
                end
                default: ;
            endcase
        end
    end

    assign upc             = pc_reg[UPC_WIDTH-1:0];
    assign acc_mem_rd_addr = acc_idx_reg;
    assign inp_mem_rd_addr = inp_idx_reg;
    assign wgt_mem_rd_addr = wgt_idx_reg;
    assign acc_mem_wr_addr = acc_idx_reg;
    assign acc_mem_wr_data = res_reg;
    assign out_mem_wr_addr = {20'd0, acc_idx_reg};
    assign acc_mem_wr_we   = {(ACC_WIDTH*ACC_DEPTH/8){state_reg == WB}};
    assign out_mem_wr_we   = {ACC_DEPTH{state_reg == WB}};
endmodule

// File: tb/tb_gemm_core.sv
// Scoreboard bench for gemm_core: behavioural memories, a reference loop model that
// queues expected write-backs, and a monitor that checks each write-back in order.
module tb_gemm_core;
    localparam int AD = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [127:0]  insn;
    logic [31:0]   uop;
    logic [12:0]   upc;
    logic [511:0]  acc_rd, acc_mem_wr_data;
    logic [11:0]   acc_mem_rd_addr, acc_mem_wr_addr;
    logic [63:0]   acc_mem_wr_we;
    logic [127:0]  inp_rd, out_mem_wr_data;
    logic [31:0]   inp_mem_rd_addr, wgt_mem_rd_addr, out_mem_wr_addr;
    logic [2047:0] wgt_rd;
    logic [15:0]   out_mem_wr_we;

    gemm_core dut (
        .clk(clk), .rst(rst), .insn(insn), .uop(uop), .upc(upc),
        .acc_mem_rd_data(acc_rd), .acc_mem_rd_addr(acc_mem_rd_addr),
        .acc_mem_wr_data(acc_mem_wr_data), .acc_mem_wr_addr(acc_mem_wr_addr),
        .acc_mem_wr_we(acc_mem_wr_we),
        .inp_mem_rd_data(inp_rd), .inp_mem_rd_addr(inp_mem_rd_addr),
        .wgt_mem_rd_data(wgt_rd), .wgt_mem_rd_addr(wgt_mem_rd_addr),
        .out_mem_wr_data(out_mem_wr_data), .out_mem_wr_addr(out_mem_wr_addr),
        .out_mem_wr_we(out_mem_wr_we)
    );

    logic [31:0]   uop_mem   [AD];
    logic [511:0]  acc_mem   [AD];
    logic [127:0]  inp_mem   [AD];
    logic [2047:0] wgt_mem   [AD];
    logic [511:0]  acc_model [AD];
    logic          acc_fill;
    logic [511:0]  acc_fill_val;
    int            cyc = 0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        uop    <= uop_mem[upc[5:0]];
        acc_rd <= acc_mem[acc_mem_rd_addr[5:0]];
        inp_rd <= inp_mem[inp_mem_rd_addr[5:0]];
        wgt_rd <= wgt_mem[wgt_mem_rd_addr[5:0]];
        if (acc_fill) begin
            for (int a = 0; a < AD; a++) acc_mem[a] <= acc_fill_val;
        end else if (acc_mem_wr_we != '0) begin
            acc_mem[acc_mem_wr_addr[5:0]] <= acc_mem_wr_data;
        end
    end

    typedef struct {
        logic [11:0]  acc_addr;
        logic [511:0] acc_data;
        logic [127:0] out_data;
        logic [31:0]  inp_addr;
        logic [31:0]  wgt_addr;
    } wb_t;
    wb_t exp_q[$];

    int tests_run = 0;
    int tests_failed = 0;
    int wb_seen = 0;
    int first_wb_cyc = -1;
    int start_cyc = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        wb_t e;
        if (acc_mem_wr_we != '0 || out_mem_wr_we != '0) begin
            wb_seen++;
            if (first_wb_cyc < 0) first_wb_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_wb", 512'(acc_mem_wr_we), 512'(0));
            end else begin
                e = exp_q.pop_front();
                $display("[TB] wb acc_addr=%0d inp_addr=%0d wgt_addr=%0d elem0=%0h",
                         acc_mem_wr_addr, inp_mem_rd_addr, wgt_mem_rd_addr, acc_mem_wr_data[31:0]);
                check("acc_addr", 512'(acc_mem_wr_addr), 512'(e.acc_addr));
                check("acc_data", acc_mem_wr_data, e.acc_data);
                check("out_addr", 512'(out_mem_wr_addr), 512'(e.acc_addr));
                check("out_data", 512'(out_mem_wr_data), 512'(e.out_data));
                check("inp_addr", 512'(inp_mem_rd_addr), 512'(e.inp_addr));
                check("wgt_addr", 512'(wgt_mem_rd_addr), 512'(e.wgt_addr));
                check("acc_we", 512'(acc_mem_wr_we), 512'({64{1'b1}}));
                check("out_we", 512'(out_mem_wr_we), 512'({16{1'b1}}));
            end
        end
    end

    function automatic logic [127:0] mk_insn(input logic rr, input int bgn, input int endv,
                                             input int iout, input int iin, input int dfo, input int dfi,
                                             input int sfo, input int sfi, input int wfo, input int wfi);
        logic [127:0] r;
        r = '0;
        r[2:0]     = 3'd2;
        r[7]       = rr;
        r[20:8]    = 13'(bgn);
        r[34:21]   = 14'(endv);
        r[48:35]   = 14'(iout);
        r[62:49]   = 14'(iin);
        r[73:63]   = 11'(dfo);
        r[84:74]   = 11'(dfi);
        r[95:85]   = 11'(sfo);
        r[106:96]  = 11'(sfi);
        r[116:107] = 10'(wfo);
        r[126:117] = 10'(wfi);
        return r;
    endfunction

    // Reference walk of the loop nest; queues at most max_wb write-backs
    task automatic push_expected(input logic [127:0] ins, input int max_wb);
        int bgn, endv, iout, iin, pushed;
        logic [31:0] u;
        int a, ip, wp, s;
        byte ib, wv;
        wb_t e;
        bgn = int'(ins[20:8]);    endv = int'(ins[34:21]);
        iout = int'(ins[48:35]);  iin = int'(ins[62:49]);
        pushed = 0;
        if (iout == 0 || iin == 0 || endv <= bgn) return;
        for (int i = 0; i < iout; i++)
            for (int j = 0; j < iin; j++)
                for (int pc = bgn; pc < endv; pc++) begin
                    if (pushed == max_wb) return;
                    u  = uop_mem[pc % AD];
                    a  = (int'(u[10:0]) + i*int'(ins[73:63]) + j*int'(ins[84:74])) & 'hfff;
                    ip = int'(u[21:11]) + i*int'(ins[95:85]) + j*int'(ins[106:96]);
                    wp = int'(u[31:22]) + i*int'(ins[116:107]) + j*int'(ins[126:117]);
                    for (int k = 0; k < 16; k++) begin
                        if (ins[7]) begin
                            s = 0;
                        end else begin
                            s = int'(acc_model[a % AD][32*k +: 32]);
                            for (int n = 0; n < 16; n++) begin
                                ib = inp_mem[ip % AD][8*n +: 8];
                                wv = wgt_mem[wp % AD][8*(16*k+n) +: 8];
                                s  = s + ib * wv;
                            end
                        end
                        acc_model[a % AD][32*k +: 32] = 32'(s);
                        e.out_data[8*k +: 8] = 8'(s);
                    end
                    e.acc_addr = 12'(a);
                    e.acc_data = acc_model[a % AD];
                    e.inp_addr = 32'(ip);
                    e.wgt_addr = 32'(wp);
                    exp_q.push_back(e);
                    pushed++;
                end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic idle_opcode();
        insn[2:0] = 3'd0;
        step(2);
    endtask

    task automatic fill_acc(input logic [31:0] v);
        acc_fill_val = {16{v}};
        acc_fill = 1'b1;
        step(1);
        acc_fill = 1'b0;
        for (int a = 0; a < AD; a++) acc_model[a] = {16{v}};
    endtask

    task automatic set_uniform(input logic [7:0] ib, input logic [7:0] wb);
        for (int a = 0; a < AD; a++) begin
            inp_mem[a] = {16{ib}};
            wgt_mem[a] = {256{wb}};
        end
    endtask

    task automatic set_random();
        for (int a = 0; a < AD; a++) begin
            for (int w = 0; w < 4; w++)  inp_mem[a][32*w +: 32] = $urandom;
            for (int w = 0; w < 64; w++) wgt_mem[a][32*w +: 32] = $urandom;
        end
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            step(1);
            c++;
        end
        if (exp_q.size() != 0) begin
            check("timeout_pending_wb", 512'(exp_q.size()), 512'(0));
            exp_q.delete();
        end
        step(20);
    endtask

    task automatic run(input logic [127:0] ins, input int budget);
        first_wb_cyc = -1;
        start_cyc = cyc;
        insn = ins;
        wait_done(budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] ins;
        rst = 1'b1;
        insn = '0;
        acc_fill = 1'b0;
        acc_fill_val = '0;
        for (int a = 0; a < AD; a++) uop_mem[a] = '0;
        set_uniform(8'd0, 8'd0);
        step(3);
        check("rst_upc", 512'(upc), 512'(0));
        check("rst_acc_we", 512'(acc_mem_wr_we), 512'(0));
        check("rst_out_we", 512'(out_mem_wr_we), 512'(0));
        check("rst_acc_wr_data", acc_mem_wr_data, 512'(0));
        check("rst_acc_rd_addr", 512'(acc_mem_rd_addr), 512'(0));
        rst = 1'b0;
        step(1);

        // single micro-op accumulate: 5 + 16*1*2 = 37
        set_uniform(8'd1, 8'd2);
        fill_acc(32'd5);
        ins = mk_insn(1'b0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        push_expected(ins, 1000);
        run(ins, 100);
        check("wb_latency", 512'(first_wb_cyc - start_cyc), 512'(5));
        check("accum_mem0", acc_mem[0], {16{32'd37}});
        wb_seen = 0;
        step(20);
        check("held_no_rerun", 512'(wb_seen), 512'(0));
        idle_opcode();
        push_expected(ins, 1000);
        run(ins, 100);
        check("rerun_mem0", acc_mem[0], {16{32'd69}});

        // signed path: 16 * (-1 * 1) = -16
        idle_opcode();
        set_uniform(8'hFF, 8'h01);
        fill_acc(32'd0);
        push_expected(ins, 1000);
        run(ins, 100);
        check("signed_mem0", acc_mem[0], {16{32'hFFFF_FFF0}});

        // reset_reg clears regardless of memory contents
        idle_opcode();
        set_random();
        fill_acc(32'd5);
        ins = mk_insn(1'b1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        push_expected(ins, 1000);
        run(ins, 100);
        check("clear_mem0", acc_mem[0], 512'(0));

        // two-level loop addressing over two micro-ops
        idle_opcode();
        set_random();
        fill_acc(32'd3);
        uop_mem[0] = {10'd0, 11'd0, 11'd0};
        uop_mem[1] = {10'd2, 11'd1, 11'd8};
        ins = mk_insn(1'b0, 0, 2, 2, 3, 4, 1, 5, 2, 3, 1);
        push_expected(ins, 1000);
        run(ins, 300);

        // degenerate instructions never write
        idle_opcode();
        wb_seen = 0;
        run(mk_insn(1'b0, 0, 2, 2, 0, 4, 1, 0, 0, 0, 0), 10);
        check("degen_iter_in0", 512'(wb_seen), 512'(0));
        idle_opcode();
        wb_seen = 0;
        run(mk_insn(1'b0, 3, 3, 1, 1, 0, 0, 0, 0, 0, 0), 10);
        check("degen_empty_range", 512'(wb_seen), 512'(0));

        // reset in the READ state of the second micro-op, then restart from uop_bgn
        idle_opcode();
        set_uniform(8'd1, 8'd2);
        fill_acc(32'd5);
        uop_mem[4] = {10'd0, 11'd0, 11'd0};
        uop_mem[5] = {10'd0, 11'd0, 11'd1};
        ins = mk_insn(1'b0, 4, 6, 1, 1, 0, 0, 0, 0, 0, 0);
        push_expected(ins, 1);
        insn = ins;
        step(8);
        rst = 1'b1;
        step(1);
        check("midrst_upc", 512'(upc), 512'(0));
        check("midrst_acc_we", 512'(acc_mem_wr_we), 512'(0));
        check("midrst_out_we", 512'(out_mem_wr_we), 512'(0));
        check("midrst_wr_data", acc_mem_wr_data, 512'(0));
        check("midrst_first_uop_done", 512'(exp_q.size()), 512'(0));
        exp_q.delete();
        step(2);
        rst = 1'b0;
        wb_seen = 0;
        push_expected(ins, 1000);
        step(1);
        check("restart_upc", 512'(upc), 512'(4));
        wait_done(100);
        check("restart_wb_count", 512'(wb_seen), 512'(2));
        check("restart_mem0", acc_mem[0], {16{32'd69}});
        check("restart_mem1", acc_mem[1], {16{32'd37}});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/gemm_core.md
Name: gemm_core

Overview:
- Matrix-multiply execution core of the VTA-style accelerator.
- Decodes one 128-bit GEMM instruction and walks a two-level loop (iter_out × iter_in) over a micro-op range [uop_bgn, uop_end).
- For each micro-op it reads a 16-element input vector, a 16×16 weight tile and a 16-element accumulator vector from external synchronous-read BRAMs, then performs acc += W·x, or clears the vector when reset_reg is set.
- It writes the result back to accumulator memory and writes the truncated 8-bit result to output memory.

Parameters:
UOP_WIDTH 32 micro-op word width
UPC_WIDTH 13 micro-op address width
INS_WIDTH 128 instruction width
INP_WIDTH 8 input element width (signed)
WGT_WIDTH 8 weight element width (signed)
ACC_WIDTH 32 accumulator element width (signed)
INP_DEPTH 16 input elements per vector (BLOCK_IN)
WGT_DEPTH 256 weight elements per tile (= INP_DEPTH*ACC_DEPTH)
ACC_DEPTH 16 accumulator/output elements per vector (BLOCK_OUT)

Ports:
clk input 1 single clock, all state on rising edge
rst input 1 reset, synchronous, active-high
insn input 128 instruction; fields [2:0] opcode, [7] reset_reg, [20:8] uop_bgn, [34:21] uop_end, [48:35] iter_out, [62:49] iter_in, [73:63] dst_factor_out, [84:74] dst_factor_in, [95:85] src_factor_out, [106:96] src_factor_in, [116:107] wgt_factor_out, [126:117] wgt_factor_in; bits [6:3] and [127] ignored
uop input 32 micro-op from uop memory, valid 1 cycle after upc; [10:0] acc idx, [21:11] inp idx, [31:22] wgt idx
upc output 13 micro-op memory address
acc_mem_rd_data input 512 accumulator vector; element k at [32k+:32]
acc_mem_rd_addr output 12 accumulator read index
acc_mem_wr_data output 512 accumulator write vector
acc_mem_wr_addr output 12 accumulator write index
acc_mem_wr_we output 64 byte enables
inp_mem_rd_data input 128 input vector; element n at [8n+:8]
inp_mem_rd_addr output 32 input index
wgt_mem_rd_data input 2048 weight tile; W[k][n] at [8(16k+n)+:8]
wgt_mem_rd_addr output 32 weight index
out_mem_wr_data output 128 output vector; element k at [8k+:8]
out_mem_wr_addr output 32 output index
out_mem_wr_we output 16 byte enables

Behaviour:
- Memories are external with 1-cycle synchronous read: data is valid the cycle after the address is presented.
- FSM states: IDLE, FETCH, DECODE, READ, EXEC, WB, DONE.
- IDLE: if opcode==3'd2 (GEMM), capture the insn fields.
  - If iter_out==0, iter_in==0 or uop_end<=uop_bgn, go to DONE.
  - Otherwise set i=0, j=0, pc=uop_bgn and go to FETCH.
- FETCH: upc=pc.
- DECODE: uop is valid. Register the indices:
  - acc_idx = uop[10:0] + i*dst_factor_out + j*dst_factor_in, truncated to 12 bits.
  - inp_idx = uop[21:11] + i*src_factor_out + j*src_factor_in, 32-bit.
  - wgt_idx = uop[31:22] + i*wgt_factor_out + j*wgt_factor_in, 32-bit.
- READ: drive acc_mem_rd_addr=acc_idx, inp_mem_rd_addr=inp_idx, wgt_mem_rd_addr=wgt_idx.
- EXEC: data is valid. For each k, register:
  - new[k] = 0 if reset_reg.
  - Otherwise new[k] = acc[k] + Σn sext(inp[n])*sext(W[k][n]).
  - Arithmetic is signed, and the 32-bit wrap-around result is kept.
- WB, for exactly 1 cycle:
  - acc_mem_wr_addr=acc_idx, acc_mem_wr_data=new, acc_mem_wr_we=all ones.
  - out_mem_wr_addr=zero-extended acc_idx, out_mem_wr_data[k]=new[k][7:0], out_mem_wr_we=all ones.
  - Then advance the loop: pc++. If pc==uop_end: pc=uop_bgn, j++. If j==iter_in: j=0, i++. If i==iter_out: go to DONE, else go to FETCH.
- Loop order: i outermost, pc innermost. Each micro-op takes exactly 5 cycles, with no overlap, so there is no accumulator read-after-write hazard.
- DONE: remain until opcode!=3'd2, then go to IDLE. Consequence: a held GEMM insn executes exactly once.
- Write enables are 0 in every state except WB.
- Reset, synchronous, in any state including mid-instruction:
  - Next state is IDLE; the partial loop is abandoned.
  - upc, all addresses and write data go to 0; all write enables go to 0 in the following cycle.
- Field changes on insn during execution are ignored because fields are latched in IDLE.

Test Plan:
- Single-uop accumulate: inp all 1, wgt all 2, acc[0] all 5, uop=0, bgn=0, end=1, iters 1/1 → one WB at acc addr 0 with each element 37 and out bytes 0x25; WB occurs on the 5th cycle after leaving IDLE.
- Signed path: inp all 0xFF, wgt all 0x01, acc 0 → each acc element 0xFFFFFFF0, out bytes 0xF0.
- reset_reg=1 with nonzero memories → acc and out written with all zeros; the weights do not matter.
- Loop addressing: iter_out=2, iter_in=3, dst_factor_out=4, dst_factor_in=1, 2 uops (acc idx 0,8) → 12 WBs in order 0,8,1,9,2,10,4,12,5,13,6,14; same pattern checked on inp/wgt addresses.
- Degenerate: iter_in=0 or uop_end==uop_bgn → no write enable ever asserted; FSM reaches DONE. Holding the GEMM insn does not re-execute; toggling opcode to 0 and back to 2 re-executes, giving 37→69 on the accumulate case.
- rst asserted during READ of the 2nd uop → no further writes; upc=0 next cycle; after release a held GEMM restarts from uop_bgn.
